// File: rtl/cache_refill_pkg.sv
// Shared widths and encodings for the cache line-refill engine.
// Imported by the refill FSM and its line buffer.
package cache_refill_pkg;
  localparam int ADDR_WIDTH      = 32;
  localparam int DATA_WIDTH      = 32;
  localparam int CACHE_DEPTH     = 8;
  localparam int CACHE_OFFSET_AW = 4;
  localparam int CACHE_BANK_NUM  = 4;
  localparam int RAM_NUM         = 4;
  localparam int BEAT_CNT_W      = 2;

  typedef enum logic [1:0] {
    REFILL_IDLE  = 2'd0,
    REFILL_REQ   = 2'd1,
    REFILL_RECV  = 2'd2,
    REFILL_WRITE = 2'd3
  } refill_state_e;
endpackage

// File: rtl/cache_refill_line_buf.sv
// Beat collector for a refill: word registers, write pointer
// and critical-word capture.
import cache_refill_pkg::*;

module refill_line_buf #(
  parameter int DATA_W   = DATA_WIDTH,
  parameter int BEAT_NUM = CACHE_BANK_NUM,
  parameter int CNT_W    = BEAT_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_we,
  input  logic [DATA_W-1:0]          i_data,
  input  logic [CNT_W-1:0]           i_crit_sel,
  output logic                       o_last,
  output logic [DATA_W*BEAT_NUM-1:0] o_line,
  output logic                       o_crit_valid,
  output logic [DATA_W-1:0]          o_crit_data
);

  logic [DATA_W-1:0] r_word [BEAT_NUM];
  logic [CNT_W-1:0]  r_cnt;
  logic              r_crit_valid;
  logic [DATA_W-1:0] r_crit_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
      for (int i = 0; i < BEAT_NUM; i++)
        r_word[i] <= '0;
    end else begin
      r_crit_valid <= 1'b0;
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_we) begin
        r_word[r_cnt] <= i_data;
        r_cnt         <= r_cnt + 1'b1;
        if (r_cnt == i_crit_sel) begin
          r_crit_valid <= 1'b1;
          r_crit_data  <= i_data;
        end
      end
    end
  end

  assign o_last = i_we && (r_cnt == CNT_W'(BEAT_NUM - 1));

  for (genvar g = 0; g < BEAT_NUM; g++) begin : g_line
    assign o_line[g*DATA_W +: DATA_W] = r_word[g];
  end

  assign o_crit_valid = r_crit_valid;
  assign o_crit_data  = r_crit_data;

endmodule

// File: rtl/cache_refill.sv
// Cache line-refill engine: one line read, 4 beats collected,
// whole line written to the 4-bank data array in one cycle.
import cache_refill_pkg::*;

module cache_refill #(
  parameter int ADDR_W   = ADDR_WIDTH,
  parameter int DATA_W   = DATA_WIDTH,
  parameter int IDX_W    = CACHE_DEPTH,
  parameter int OFF_W    = CACHE_OFFSET_AW,
  parameter int BEAT_NUM = CACHE_BANK_NUM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     refill_req_i,
  input  logic [ADDR_W-1:0]        refill_addr_i,
  output logic                     refill_busy_o,
  output logic                     refill_done_o,
  output logic                     refill_err_o,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  input  logic                     mem_err_i,
  output logic                     crit_valid_o,
  output logic [DATA_W-1:0]        crit_data_o,
  output logic [IDX_W-1:0]         wr_index_o,
  output logic [OFF_W-1:0]         wr_offset_o,
  output logic [3:0]               wr_en_o,
  output logic                     wr_full_bank_o,
  output logic [DATA_W*BEAT_NUM-1:0] wr_data_o
);

  refill_state_e     r_state;
  refill_state_e     w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic              w_latch;
  logic              w_clr;
  logic              w_we;
  logic              w_last;
  logic              w_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= REFILL_IDLE;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == REFILL_RECV)
                 && mem_rvalid_i && mem_err_i;
      if (w_latch)
        r_addr <= refill_addr_i;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_clr   = 1'b0;
    w_we    = 1'b0;
    unique case (r_state)
      REFILL_IDLE: begin
        if (refill_req_i) begin
          w_latch = 1'b1;
          w_next  = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        if (mem_gnt_i) begin
          w_clr  = 1'b1;
          w_next = REFILL_RECV;
        end
      end
      REFILL_RECV: begin
        if (mem_rvalid_i) begin
          if (mem_err_i) begin
            w_next = REFILL_IDLE;
          end else begin
            w_we = 1'b1;
            if (w_last)
              w_next = REFILL_WRITE;
          end
        end
      end
      REFILL_WRITE: w_next = REFILL_IDLE;
      default:      w_next = REFILL_IDLE;
    endcase
  end

  // Word select of the miss address picks the critical beat.
  refill_line_buf #(
    .DATA_W   (DATA_W),
    .BEAT_NUM (BEAT_NUM),
    .CNT_W    (BEAT_CNT_W)
  ) u_line_buf (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_clr),
    .i_we         (w_we),
    .i_data       (mem_rdata_i),
    .i_crit_sel   (r_addr[OFF_W-1:2]),
    .o_last       (w_last),
    .o_line       (wr_data_o),
    .o_crit_valid (crit_valid_o),
    .o_crit_data  (crit_data_o)
  );

  assign w_write        = (r_state == REFILL_WRITE);
  assign refill_busy_o  = (r_state != REFILL_IDLE);
  assign refill_done_o  = w_write;
  assign refill_err_o   = r_err;
  assign mem_req_o      = (r_state == REFILL_REQ);
  assign mem_addr_o     = {r_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign wr_index_o     = r_addr[OFF_W +: IDX_W];
  assign wr_offset_o    = r_addr[OFF_W-1:0];
  assign wr_en_o        = {4{w_write}};
  assign wr_full_bank_o = w_write;

endmodule
